// File: rtl/mux_scan_sel_if.sv
// Bus bundle for the registered N-channel selector: control and packed channel
// data in, selected sample plus sample/sweep strobes out.
interface mux_scan_sel_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 4
);
    localparam int SEL_W = $clog2(CHANNELS);

    logic                      en;
    logic                      mode;
    logic [SEL_W-1:0]          sel_in;
    logic [CHANNELS*WIDTH-1:0] din;
    logic [WIDTH-1:0]          dout;
    logic [SEL_W-1:0]          sel_out;
    logic                      valid;
    logic                      wrap;

    modport master (
        output en, mode, sel_in, din,
        input  dout, sel_out, valid, wrap
    );

    modport slave (
        input  en, mode, sel_in, din,
        output dout, sel_out, valid, wrap
    );
endinterface

// File: rtl/mux_scan_sel.sv
// Registered N-channel selector with manual select and an auto-scan sequencer
// that dwells DWELL cycles per channel, flagging settled samples and sweep ends.
module mux_scan_sel #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 4,
    parameter int DWELL    = 3,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic           clk,
    input  logic           rst_n,
    mux_scan_sel_if.slave  bus
);

    localparam int                CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int                SLOTS    = 1 << SEL_W;
    localparam logic [SEL_W:0]    CH_COUNT = (SEL_W + 1)'(CHANNELS);
    localparam logic [SEL_W-1:0]  CH_LAST  = SEL_W'(CHANNELS - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DWELL - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   dout_reg, dout_next;
    logic [SEL_W-1:0]   sel_out_reg, sel_out_next;
    logic               valid_reg, valid_next;
    logic               wrap_reg, wrap_next;
    logic [SEL_W-1:0]   ch_reg, ch_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;

    logic [SEL_W-1:0]   scan_ch;
    logic [CNT_W-1:0]   scan_cnt;
    logic               last_dwell;
    logic               sel_legal;

    // Select space is padded to a power of two so any sel value indexes safely.
    logic [WIDTH-1:0]   slot [SLOTS];

    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
            if (gi < CHANNELS) begin : g_used
                assign slot[gi] = bus.din[gi*WIDTH +: WIDTH];
            end else begin : g_pad
                assign slot[gi] = '0;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            dout_reg    <= '0;
            sel_out_reg <= '0;
            valid_reg   <= 1'b0;
            wrap_reg    <= 1'b0;
            ch_reg      <= '0;
            cnt_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            dout_reg    <= dout_next;
            sel_out_reg <= sel_out_next;
            valid_reg   <= valid_next;
            wrap_reg    <= wrap_next;
            ch_reg      <= ch_next;
            cnt_reg     <= cnt_next;
        end
    end

    // While frozen the state is kept so a re-enable can resume the sweep.
    always_comb begin
        state_next = state_reg;
        if (bus.en) begin
            state_next = bus.mode ? SCAN : MANUAL;
        end
    end

    // Entering scan from any other state starts at channel 0, dwell 0 on this edge.
    always_comb begin
        scan_ch    = (state_reg == SCAN) ? ch_reg  : '0;
        scan_cnt   = (state_reg == SCAN) ? cnt_reg : '0;
        last_dwell = (scan_cnt == CNT_LAST);
        sel_legal  = ({1'b0, bus.sel_in} < CH_COUNT);

        dout_next    = dout_reg;
        sel_out_next = sel_out_reg;
        valid_next   = 1'b0;
        wrap_next    = 1'b0;
        ch_next      = ch_reg;
        cnt_next     = cnt_reg;

        if (bus.en) begin
            if (!bus.mode) begin
                ch_next  = '0;
                cnt_next = '0;
                if (sel_legal) begin
                    dout_next    = slot[bus.sel_in];
                    sel_out_next = bus.sel_in;
                    valid_next   = 1'b1;
                end
            end else begin
                dout_next    = slot[scan_ch];
                sel_out_next = scan_ch;
                valid_next   = last_dwell;
                wrap_next    = last_dwell && (scan_ch == CH_LAST);
                if (last_dwell) begin
                    cnt_next = '0;
                    ch_next  = (scan_ch == CH_LAST) ? '0 : scan_ch + 1'b1;
                end else begin
                    cnt_next = scan_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.dout    = dout_reg;
    assign bus.sel_out = sel_out_reg;
    assign bus.valid   = valid_reg;
    assign bus.wrap    = wrap_reg;

    a_wrap_has_valid: assert property (@(posedge clk) disable iff (!rst_n)
        wrap_reg |-> valid_reg);
    a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n)
        cnt_reg <= CNT_LAST);
    a_ch_range: assert property (@(posedge clk) disable iff (!rst_n)
        ch_reg <= CH_LAST);

endmodule
